// File: rtl/jala_pkg.sv
// Shared execute/memory definitions: ALU opcodes, default widths, EX/MEM entry layout
// and the branch-resolution rule applied when an entry is captured.
package jala_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 3;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SLT = 3'd3,
    ALU_SUB = 3'd4
  } alu_op_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] r;
    logic                  zero;
    logic                  br_taken;
    logic [DEF_DATA_W-1:0] store_data;
    logic [DEF_REG_AW-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } ex_mem_entry_t;

  function automatic logic br_resolve(input logic eq, input logic ne, input logic zero);
    return (eq & zero) | (ne & ~zero);
  endfunction
endpackage

// File: rtl/ex_mem_slot.sv
// One pipeline entry register with valid bit. Reset clears data and valid;
// clear drops valid only and wins over load.
module ex_mem_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output logic [W-1:0] o_q
);
  logic         r_valid;
  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_q     <= i_d;
    end
  end

  assign o_valid = r_valid;
  assign o_q     = r_q;
endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM boundary with a 2-entry skid buffer (main = head, skid = overflow).
// Optional stall counter enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_skid
  import jala_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
`ifdef EX_MEM_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              br_eq,
  input  logic              br_ne,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_zero,
  output logic              out_br_taken
`ifdef EX_MEM_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_count
`endif
);
  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic              zero;
    logic              br_taken;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t w_in_entry, w_main_q, w_skid_q, w_main_d;
  logic   w_main_valid, w_skid_valid;
  logic   w_accept, w_pop;
  logic   w_main_load, w_main_clr, w_skid_load, w_skid_clr;

  assign w_in_entry = '{r: alu_r, zero: alu_zero, br_taken: br_resolve(br_eq, br_ne, alu_zero),
                        store_data: store_data, rd: rd, reg_write: reg_write,
                        mem_read: mem_read, mem_write: mem_write};

  // skid is a register, so in_ready never depends combinationally on out_ready
  assign in_ready = ~w_skid_valid;
  assign w_accept = in_valid & in_ready;
  assign w_pop    = w_main_valid & out_ready;

  // main refills from skid when it holds an entry; otherwise straight from the input
  assign w_main_d    = w_skid_valid ? w_skid_q : w_in_entry;
  assign w_main_load = ~flush & ((w_pop & w_skid_valid) | (w_accept & (~w_main_valid | w_pop)));
  assign w_main_clr  = flush | (w_pop & ~w_skid_valid & ~w_accept);
  assign w_skid_load = ~flush & w_accept & w_main_valid & (~w_pop | w_skid_valid);
  assign w_skid_clr  = flush | (w_pop & w_skid_valid & ~w_skid_load);

  ex_mem_slot #(.W(EW)) u_main (
    .clk(clk), .reset(reset), .i_load(w_main_load), .i_clr(w_main_clr),
    .i_d(w_main_d), .o_valid(w_main_valid), .o_q(w_main_q)
  );

  ex_mem_slot #(.W(EW)) u_skid (
    .clk(clk), .reset(reset), .i_load(w_skid_load), .i_clr(w_skid_clr),
    .i_d(w_in_entry), .o_valid(w_skid_valid), .o_q(w_skid_q)
  );

  assign out_valid      = w_main_valid;
  assign out_r          = w_main_q.r;
  assign out_zero       = w_main_q.zero;
  assign out_br_taken   = w_main_q.br_taken;
  assign out_store_data = w_main_q.store_data;
  assign out_rd         = w_main_q.rd;
  assign out_reg_write  = w_main_q.reg_write;
  assign out_mem_read   = w_main_q.mem_read;
  assign out_mem_write  = w_main_q.mem_write;

`ifdef EX_MEM_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // saturating; flush deliberately does not clear it
  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (w_main_valid & ~out_ready & ~(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_count = r_stall_cnt;
`endif
endmodule

// File: tb/tb_ex_mem_skid.sv
// Self-checking bench for ex_mem_skid: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_ex_mem_skid;
  localparam int DW = 16;
  localparam int AW = 3;

  typedef struct packed {
    logic [DW-1:0] r;
    logic          zero;
    logic          taken;
    logic [DW-1:0] sd;
    logic [AW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          mw;
  } ent_t;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, alu_zero, reg_write, mem_read, mem_write;
  logic br_eq, br_ne, flush, out_valid, out_ready;
  logic [DW-1:0] alu_r, store_data, out_r, out_store_data;
  logic [AW-1:0] rd, out_rd;
  logic out_reg_write, out_mem_read, out_mem_write, out_zero, out_br_taken;
`ifdef EX_MEM_STALL_CNT_EN
  logic [3:0] stall_count;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ex_mem_skid #(
    .DATA_W(DW), .REG_AW(AW)
`ifdef EX_MEM_STALL_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_r(alu_r), .alu_zero(alu_zero), .store_data(store_data), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .br_eq(br_eq), .br_ne(br_ne), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_zero(out_zero), .out_br_taken(out_br_taken)
`ifdef EX_MEM_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; alu_r = '0; alu_zero = 0; store_data = '0; rd = '0;
    reg_write = 0; mem_read = 0; mem_write = 0; br_eq = 0; br_ne = 0;
    flush = 0; out_ready = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; in_valid = 1; alu_r = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_r !== 16'h0)
        $display("FAIL reset cyc%0d: out_valid=%b in_ready=%b out_r=%h, want 0 1 0000",
                 i, out_valid, in_ready, out_r);
      else n_pass++;
    end
    reset = 0; in_valid = 0;
  endtask

  task automatic test_stream();
    out_ready = 1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1; alu_r = 16'(i);
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_r !== 16'(i) || in_ready !== 1'b1)
        $display("FAIL stream%0d: valid=%b r=%h rdy=%b, want 1 %h 1", i, out_valid, out_r, in_ready, 16'(i));
      else n_pass++;
    end
    in_valid = 0;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL stream_drain: out_valid=%b, want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_r [7];
    logic          exp_rdy [7];
    logic          exp_v [7];
    exp_r   = '{16'hA1, 16'hA1, 16'hA1, 16'hA2, 16'hA3, 16'h0, 16'h0};
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_v   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    out_ready = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid  = (c < 5);
      alu_r     = (c == 0) ? 16'hA1 : (c == 1) ? 16'hA2 : 16'hA3;
      out_ready = (c >= 3);
      tick();
      n_total++;
      if (out_valid !== exp_v[c] || in_ready !== exp_rdy[c] || (exp_v[c] && out_r !== exp_r[c]))
        $display("FAIL backpressure cyc%0d: valid=%b rdy=%b r=%h, want %b %b %h",
                 c, out_valid, in_ready, out_r, exp_v[c], exp_rdy[c], exp_r[c]);
      else n_pass++;
      // A3 is delivered once at cyc4; stop offering it afterwards
      if (c == 4) in_valid = 0;
    end
    in_valid = 0;
  endtask

  task automatic test_branch();
    logic          t_eq [4];
    logic          t_ne [4];
    logic          t_z [4];
    logic [DW-1:0] t_r [4];
    logic          t_exp [4];
    t_eq = '{1, 0, 0, 1}; t_ne = '{0, 1, 1, 1}; t_z = '{1, 1, 0, 0};
    t_r = '{16'h0, 16'h0, 16'h8000, 16'h0042}; t_exp = '{1, 0, 1, 1};
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; br_eq = t_eq[i]; br_ne = t_ne[i]; alu_zero = t_z[i]; alu_r = t_r[i];
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_br_taken !== t_exp[i] || out_zero !== t_z[i] || out_r !== t_r[i])
        $display("FAIL branch%0d: valid=%b taken=%b zero=%b r=%h, want 1 %b %b %h",
                 i, out_valid, out_br_taken, out_zero, out_r, t_exp[i], t_z[i], t_r[i]);
      else n_pass++;
    end
    in_valid = 0; br_eq = 0; br_ne = 0; alu_zero = 0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 0;
    in_valid = 1; alu_r = 16'hF1; tick();
    alu_r = 16'hF2; tick();
    n_total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_r !== 16'hF1)
      $display("FAIL flush_fill: rdy=%b valid=%b r=%h, want 0 1 00f1", in_ready, out_valid, out_r);
    else n_pass++;
    flush = 1; in_valid = 1; out_ready = 1; alu_r = 16'hF3;
    tick();
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush: valid=%b rdy=%b, want 0 1", out_valid, in_ready);
    else n_pass++;
    flush = 0; in_valid = 0;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL flush_after: out_valid=%b, want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    ent_t mq[$];
    ent_t e, got;
    logic acc, pop;
    clear_inputs();
    reset = 1; tick(); reset = 0;
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      n_total++;
      got = '{out_r, out_zero, out_br_taken, out_store_data, out_rd, out_reg_write,
              out_mem_read, out_mem_write};
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
          (mq.size() > 0 && got !== mq[0]))
        $display("FAIL random cyc%0d: valid=%b rdy=%b head=%h, want %b %b %h", c, out_valid,
                 in_ready, got, mq.size() > 0, mq.size() < 2, (mq.size() > 0) ? mq[0] : '0);
      else n_pass++;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 59) == 0);
      alu_r = 16'($urandom); store_data = 16'($urandom); rd = 3'($urandom);
      alu_zero = 1'($urandom); br_eq = 1'($urandom); br_ne = 1'($urandom);
      reg_write = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
      e.r = alu_r; e.zero = alu_zero; e.sd = store_data; e.rd = rd;
      e.taken = (br_eq && alu_zero) || (br_ne && !alu_zero);
      e.rw = reg_write; e.mr = mem_read; e.mw = mem_write;
      acc = in_valid && (mq.size() < 2);
      pop = out_ready && (mq.size() > 0);
      tick();
      if (reset || flush) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(e);
      end
    end
    clear_inputs();
    reset = 0;
  endtask

`ifdef EX_MEM_STALL_CNT_EN
  task automatic test_stall_cnt();
    int exp_cnt;
    clear_inputs();
    reset = 1; tick(); reset = 0;
    n_total++;
    if (stall_count !== 4'h0) $display("FAIL stall_reset: cnt=%h, want 0", stall_count);
    else n_pass++;
    in_valid = 1; alu_r = 16'h5A; tick(); in_valid = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_cnt = (k > 15) ? 15 : k;
      n_total++;
      if (stall_count !== 4'(exp_cnt)) $display("FAIL stall%0d: cnt=%h, want %h", k, stall_count, 4'(exp_cnt));
      else n_pass++;
    end
    flush = 1; tick(); flush = 0;
    n_total++;
    if (stall_count !== 4'hF) $display("FAIL stall_flush: cnt=%h, want f", stall_count);
    else n_pass++;
  endtask
`endif

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_flush();
    test_random();
`ifdef EX_MEM_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
